// File: rtl/bin_to_bcd4.sv
// rtl/bin_to_bcd4.sv - sequential shift-and-add-3 binary to 4-digit BCD converter
// Results are held in output registers and only updated on the commit cycle.
module bin_to_bcd4 #(
   parameter int DW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] bin,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic [3:0]    x0,
   output logic [3:0]    x1,
   output logic [3:0]    x2,
   output logic [3:0]    x3
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(DW);

   state_t        state_q, state_d;
   logic [DW-1:0] bin_sr_q, bin_sr_d;
   logic [15:0]   scratch_q, scratch_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ovf_pend_q, ovf_pend_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   x_q, x_d;
   logic [14:0]   adj;
   logic [13:0]   bin_ext;

   assign bin_ext = 14'(bin);

   always_comb begin
      adj = '0;
      for (int i = 0; i < 3; i++) begin
         adj[i*4 +: 4] = scratch_q[i*4 +: 4] + ((scratch_q[i*4 +: 4] >= 4'd5) ? 4'd3 : 4'd0);
      end
      // The thousands nibble's carry-out is shifted away; it only matters above 9999.
      adj[14:12] = 3'(scratch_q[15:12] + ((scratch_q[15:12] >= 4'd5) ? 4'd3 : 4'd0));
   end

   always_comb begin
      state_d    = state_q;
      bin_sr_d   = bin_sr_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      x_d        = x_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_sr_d   = bin;
               scratch_d  = '0;
               cnt_d      = CNT_INIT;
               ovf_pend_d = (bin_ext > 14'd9999);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {adj, bin_sr_q[DW-1]};
            bin_sr_d  = {bin_sr_q[DW-2:0], 1'b0};
            cnt_d     = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            done_d  = 1'b1;
            ovf_d   = ovf_pend_q;
            x_d     = ovf_pend_q ? 16'hFFFF : scratch_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_sr_q   <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         x_q        <= '0;
      end else begin
         state_q    <= state_d;
         bin_sr_q   <= bin_sr_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         x_q        <= x_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign ovf  = ovf_q;
   assign x0   = x_q[3:0];
   assign x1   = x_q[7:4];
   assign x2   = x_q[11:8];
   assign x3   = x_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd4.sv
// tb/tb_bin_to_bcd4.sv - randomized self-checking bench for bin_to_bcd4
// Expected digits come from decimal arithmetic on the input value.
module tb_bin_to_bcd4;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] bin;
   logic          start;
   logic          busy, done, ovf;
   logic [3:0]    x0, x1, x2, x3;

   int n_checks = 0;
   int n_fails  = 0;

   bin_to_bcd4 #(.DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .bin   (bin),
      .start (start),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .x0    (x0),
      .x1    (x1),
      .x2    (x2),
      .x3    (x3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_digits(input int v);
      if (v > 9999) return 16'hFFFF;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] digits();
      return {x3, x2, x1, x0};
   endfunction

   task automatic run_conv(input int v, input string tag);
      logic [15:0] prev_x;
      logic        prev_ovf;
      logic        stable_ok;
      logic        busy_ok;
      int          lat;
      prev_x    = digits();
      prev_ovf  = ovf;
      stable_ok = 1'b1;
      busy_ok   = 1'b1;
      bin   = DW'(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      bin   = DW'($urandom_range(0, 16383));
      lat   = 0;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (digits() !== prev_x || ovf !== prev_ovf) stable_ok = 1'b0;
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, lat, DW + 1);
      check_eq({tag, "_busy_during"}, busy_ok, 1'b1);
      check_eq({tag, "_held"}, stable_ok, 1'b1);
      check_eq({tag, "_busy_at_done"}, busy, 1'b0);
      check_eq({tag, "_digits"}, digits(), ref_digits(v));
      check_eq({tag, "_ovf"}, ovf, (v > 9999));
      tick();
      check_eq({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      int k;
      int pulses;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      tick();
      tick();
      rst = 1'b0;
      check_eq("reset_digits", digits(), 16'h0);
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_done", done, 1'b0);
      check_eq("reset_ovf", ovf, 1'b0);
      repeat (3) tick();
      check_eq("idle_digits", digits(), 16'h0);
      check_eq("idle_busy", busy, 1'b0);

      run_conv(1234, "v1234");
      run_conv(0, "v0");
      run_conv(9999, "v9999");
      run_conv(10000, "v10000");
      run_conv(16383, "v16383");
      run_conv(7, "v7");

      for (int i = 0; i < 16; i++) begin
         int v;
         v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
         run_conv(v, $sformatf("rnd%0d_%0d", i, v));
      end

      // start held high; second request is accepted during the done cycle
      bin   = DW'(42);
      start = 1'b1;
      tick();
      k = 0;
      while (!done && k < 40) begin
         if (k == 4) bin = DW'(999);
         tick();
         k++;
      end
      check_eq("b2b_first_latency", k, DW + 1);
      check_eq("b2b_first_digits", digits(), 16'h0042);
      k = 0;
      do begin
         tick();
         k++;
      end while (!done && k < 40);
      start = 1'b0;
      check_eq("b2b_spacing", k, DW + 2);
      check_eq("b2b_second_digits", digits(), 16'h0999);
      check_eq("b2b_second_ovf", ovf, 1'b0);
      repeat (2) tick();

      // a start while busy is dropped
      bin   = DW'(5678);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      bin   = DW'(1111);
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 3;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      check_eq("ign_latency", k, DW + 1);
      check_eq("ign_digits", digits(), 16'h5678);
      pulses = 0;
      repeat (20) begin
         tick();
         if (done) pulses++;
      end
      check_eq("ign_extra_done", pulses, 0);
      check_eq("ign_digits_kept", digits(), 16'h5678);

      // reset mid-conversion discards the result
      bin   = DW'(4321);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      check_eq("abort_digits", digits(), 16'h0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_done", done, 1'b0);
      check_eq("abort_ovf", ovf, 1'b0);
      rst = 1'b0;
      pulses = 0;
      repeat (25) begin
         tick();
         if (done) pulses++;
      end
      check_eq("abort_no_done", pulses, 0);
      check_eq("abort_digits_kept", digits(), 16'h0);
      run_conv(250, "v0250");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
